bp_update_ctrl: RTL and testbench

Single-write-port update scheduler for the branch predictor tables: tag, target (BTB) and 2-bit counter (BHT).
- Accepts ID-stage BTB allocate requests through a 2-deep FIFO and EX-stage BHT outcome updates directly.
- Arbitrates the two onto one row-write port and computes the saturating-counter read-modify-write.
- Sequences a one-entry-per-cycle clear walk after reset or a flush request, replacing the predictor's own bulk clear.

---
 rtl/bp_update_ctrl_pkg.sv | 28 ++
 rtl/bp_update_ctrl_if.sv | 38 +++
 rtl/bp_upd_fifo.sv | 65 ++++++
 rtl/bp_update_ctrl.sv | 173 +++++++++++++++++
 tb/tb_bp_update_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_update_ctrl_pkg.sv
// rtl/bp_update_ctrl_pkg.sv - shared widths, encodings and counter helper for the predictor update scheduler
package bp_update_ctrl_pkg;

  localparam int WORD_SIZE    = 16;
  localparam int BTB_IDX_SIZE = 8;
  localparam int TAG_W        = WORD_SIZE - BTB_IDX_SIZE;

  localparam logic [TAG_W-1:0] TAG_INIT = TAG_W'(1);
  localparam logic [1:0]       BHT_INIT = 2'b10;
  localparam logic [1:0]       WR_ROW   = 2'b11;
  localparam logic [1:0]       WR_BHT   = 2'b01;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] target;
  } id_entry_t;

  function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
    if (taken) return (cur == 2'b11) ? cur : cur + 2'b01;
    return (cur == 2'b00) ? cur : cur - 2'b01;
  endfunction

endpackage

// File: rtl/bp_update_ctrl_if.sv
// rtl/bp_update_ctrl_if.sv - update request, table read and table write bundle
interface bp_update_ctrl_if;
  import bp_update_ctrl_pkg::*;

  logic                    id_upd_valid;
  logic                    id_upd_ready;
  logic [WORD_SIZE-1:0]    id_upd_pc;
  logic [WORD_SIZE-1:0]    id_upd_target;
  logic                    ex_upd_valid;
  logic [WORD_SIZE-1:0]    ex_upd_pc;
  logic                    ex_upd_taken;
  logic [BTB_IDX_SIZE-1:0] rd_idx;
  logic [TAG_W-1:0]        rd_tag;
  logic [1:0]              rd_bht;
  logic                    wr_en;
  logic [1:0]              wr_mask;
  logic [BTB_IDX_SIZE-1:0] wr_idx;
  logic [TAG_W-1:0]        wr_tag;
  logic [WORD_SIZE-1:0]    wr_target;
  logic [1:0]              wr_bht;

  modport slave (
    input  id_upd_valid, id_upd_pc, id_upd_target,
    input  ex_upd_valid, ex_upd_pc, ex_upd_taken,
    input  rd_tag, rd_bht,
    output id_upd_ready, rd_idx,
    output wr_en, wr_mask, wr_idx, wr_tag, wr_target, wr_bht
  );

  modport master (
    output id_upd_valid, id_upd_pc, id_upd_target,
    output ex_upd_valid, ex_upd_pc, ex_upd_taken,
    output rd_tag, rd_bht,
    input  id_upd_ready, rd_idx,
    input  wr_en, wr_mask, wr_idx, wr_tag, wr_target, wr_bht
  );

endinterface

// File: rtl/bp_upd_fifo.sv
// rtl/bp_upd_fifo.sv - two-entry queue of ID allocate requests; flush wins over push
module bp_upd_fifo
  import bp_update_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  id_entry_t push_data,
  input  logic      pop,
  output id_entry_t head,
  output logic      full,
  output logic      empty
);

  id_entry_t  mem_q [2];
  id_entry_t  mem_d [2];
  logic       wptr_q, wptr_d;
  logic       rptr_q, rptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign head  = mem_q[rptr_q];

  // a full queue still takes a push when the head leaves in the same cycle
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = 1'b0;
      rptr_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = push_data;
        wptr_d        = ~wptr_q;
      end
      if (do_pop) rptr_d = ~rptr_q;
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// rtl/bp_update_ctrl.sv - single write port scheduler for BTB/BHT updates with clear walk
// BP_UPD_STATS_EN adds saturating BHT-write and ID-stall counters.
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic flush_req,
  output logic busy,
`ifdef BP_UPD_STATS_EN
  output logic [15:0] stat_bht_upd,
  output logic [15:0] stat_id_stall,
`endif
  bp_update_ctrl_if.slave bus
);

  state_e                  state_q, state_d;
  logic [BTB_IDX_SIZE-1:0] cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    wr_en_q, wr_en_d;
  logic [1:0]              wr_mask_q, wr_mask_d;
  logic [BTB_IDX_SIZE-1:0] wr_idx_q, wr_idx_d;
  logic [TAG_W-1:0]        wr_tag_q, wr_tag_d;
  logic [WORD_SIZE-1:0]    wr_target_q, wr_target_d;
  logic [1:0]              wr_bht_q, wr_bht_d;

  id_entry_t               fifo_head;
  logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                    id_ready;
  logic [BTB_IDX_SIZE-1:0] ex_idx;
  logic [TAG_W-1:0]        ex_tag, cur_tag;
  logic [1:0]              cur_bht;
  logic                    pend_hit;

  assign ex_idx      = bus.ex_upd_pc[BTB_IDX_SIZE-1:0];
  assign ex_tag      = bus.ex_upd_pc[WORD_SIZE-1:BTB_IDX_SIZE];
  assign bus.rd_idx  = ex_idx;
  assign id_ready    = (state_q == ST_RUN) && !fifo_full;
  assign bus.id_upd_ready = id_ready;
  assign fifo_push   = bus.id_upd_valid && id_ready;

  // the write on wr_* lands at the coming edge, so the table read is one write stale
  assign pend_hit = wr_en_q && (wr_idx_q == ex_idx);
  assign cur_tag  = (pend_hit && wr_mask_q[1]) ? wr_tag_q : bus.rd_tag;
  assign cur_bht  = (pend_hit && wr_mask_q[0]) ? wr_bht_q : bus.rd_bht;

  bp_upd_fifo u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .flush     (flush_req),
    .push      (fifo_push),
    .push_data ({bus.id_upd_pc, bus.id_upd_target}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    wr_en_d     = 1'b0;
    wr_mask_d   = 2'b00;
    wr_idx_d    = '0;
    wr_tag_d    = '0;
    wr_target_d = '0;
    wr_bht_d    = 2'b00;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (flush_req) begin
          cnt_d = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_mask_d = WR_ROW;
          wr_idx_d  = cnt_q;
          wr_tag_d  = TAG_INIT;
          wr_bht_d  = BHT_INIT;
          cnt_d     = cnt_q + BTB_IDX_SIZE'(1);
          if (cnt_q == {BTB_IDX_SIZE{1'b1}}) begin
            state_d = ST_RUN;
            busy_d  = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (flush_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (bus.ex_upd_valid) begin
          // a tag miss means the row was reallocated; the outcome is simply dropped
          if (cur_tag == ex_tag) begin
            wr_en_d   = 1'b1;
            wr_mask_d = WR_BHT;
            wr_idx_d  = ex_idx;
            wr_bht_d  = bht_next(cur_bht, bus.ex_upd_taken);
          end
        end else if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          wr_en_d     = 1'b1;
          wr_mask_d   = WR_ROW;
          wr_idx_d    = fifo_head.pc[BTB_IDX_SIZE-1:0];
          wr_tag_d    = fifo_head.pc[WORD_SIZE-1:BTB_IDX_SIZE];
          wr_target_d = fifo_head.target;
          wr_bht_d    = BHT_INIT;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      busy_q      <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_mask_q   <= 2'b00;
      wr_idx_q    <= '0;
      wr_tag_q    <= '0;
      wr_target_q <= '0;
      wr_bht_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_mask_q   <= wr_mask_d;
      wr_idx_q    <= wr_idx_d;
      wr_tag_q    <= wr_tag_d;
      wr_target_q <= wr_target_d;
      wr_bht_q    <= wr_bht_d;
    end
  end

  assign busy          = busy_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_mask   = wr_mask_q;
  assign bus.wr_idx    = wr_idx_q;
  assign bus.wr_tag    = wr_tag_q;
  assign bus.wr_target = wr_target_q;
  assign bus.wr_bht    = wr_bht_q;

`ifdef BP_UPD_STATS_EN
  logic [15:0] stat_bht_q, stat_bht_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_bht_d   = stat_bht_q;
    stat_stall_d = stat_stall_q;
    if (wr_en_d && (wr_mask_d == WR_BHT) && (stat_bht_q != 16'hFFFF))
      stat_bht_d = stat_bht_q + 16'd1;
    if (bus.id_upd_valid && !id_ready && (stat_stall_q != 16'hFFFF))
      stat_stall_d = stat_stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_bht_q   <= 16'd0;
      stat_stall_q <= 16'd0;
    end else begin
      stat_bht_q   <= stat_bht_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_bht_upd  = stat_bht_q;
  assign stat_id_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb/tb_bp_update_ctrl.sv - randomized self-checking bench for bp_update_ctrl
module tb_bp_update_ctrl;
  import bp_update_ctrl_pkg::*;

  localparam int DEPTH = 1 << BTB_IDX_SIZE;

  logic clk = 1'b0;
  logic reset_n;
  logic flush_req;
  logic busy;
`ifdef BP_UPD_STATS_EN
  logic [15:0] stat_bht_upd, stat_id_stall;
`endif

  bp_update_ctrl_if bus();

  bp_update_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush_req     (flush_req),
    .busy          (busy),
`ifdef BP_UPD_STATS_EN
    .stat_bht_upd  (stat_bht_upd),
    .stat_id_stall (stat_id_stall),
`endif
    .bus           (bus.slave)
  );

  always #5 clk = ~clk;

  // predictor table emulation: written at the edge a write is presented, read combinationally
  logic [TAG_W-1:0] env_tag [DEPTH];
  logic [1:0]       env_bht [DEPTH];
  assign bus.rd_tag = env_tag[bus.rd_idx];
  assign bus.rd_bht = env_bht[bus.rd_idx];

  always @(posedge clk) begin
    if (bus.wr_en) begin
      if (bus.wr_mask[1]) env_tag[bus.wr_idx] = bus.wr_tag;
      if (bus.wr_mask[0]) env_bht[bus.wr_idx] = bus.wr_bht;
    end
  end

  // reference model: logical table contents after every scheduled write, plus a request queue
  bit          m_run;
  int          m_cnt;
  logic [31:0] q [$];
  int          mt_tag [DEPTH];
  int          mt_bht [DEPTH];

  logic [37:0] exp_w;
  logic        exp_ready;
  logic        ready_seen;
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [37:0] norm(input logic b, input logic en, input logic [1:0] m,
                                       input logic [7:0] idx, input logic [7:0] tag,
                                       input logic [15:0] tgt, input logic [1:0] bht);
    if (!en) return {b, 37'd0};
    if (m == 2'b01) return {b, en, m, idx, 8'd0, 16'd0, bht};
    return {b, en, m, idx, tag, tgt, bht};
  endfunction

  function automatic logic [37:0] act_w();
    return norm(busy, bus.wr_en, bus.wr_mask, bus.wr_idx, bus.wr_tag, bus.wr_target, bus.wr_bht);
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_cnt = 0;
    q.delete();
  endtask

  task automatic preset(input logic [7:0] idx, input logic [7:0] tag, input logic [1:0] bht);
    env_tag[idx] = tag;
    env_bht[idx] = bht;
    mt_tag[idx]  = int'(tag);
    mt_bht[idx]  = int'(bht);
  endtask

  task automatic cyc(input logic fl, input logic idv, input logic [15:0] idpc, input logic [15:0] idtgt,
                     input logic exv, input logic [15:0] expc, input logic ext);
    logic        e_en;
    logic [1:0]  e_m;
    logic [7:0]  e_idx, e_tag;
    logic [15:0] e_tgt;
    logic [1:0]  e_bht;
    logic [31:0] ent;
    int          b;
    flush_req         = fl;
    bus.id_upd_valid  = idv;
    bus.id_upd_pc     = idpc;
    bus.id_upd_target = idtgt;
    bus.ex_upd_valid  = exv;
    bus.ex_upd_pc     = expc;
    bus.ex_upd_taken  = ext;
    #1;
    ready_seen = bus.id_upd_ready;
    exp_ready  = m_run && (q.size() < 2);
    e_en = 0; e_m = 0; e_idx = 0; e_tag = 0; e_tgt = 0; e_bht = 0;
    if (!m_run) begin
      if (fl) m_cnt = 0;
      else begin
        e_en = 1; e_m = 2'b11; e_idx = m_cnt[7:0]; e_tag = 8'd1; e_bht = 2'b10;
        if (m_cnt == DEPTH - 1) begin m_run = 1'b1; m_cnt = 0; end
        else m_cnt++;
      end
    end else if (fl) begin
      model_reset();
    end else begin
      if (exv) begin
        if (mt_tag[expc[7:0]] == int'(expc[15:8])) begin
          b = mt_bht[expc[7:0]] + (ext ? 1 : -1);
          if (b > 3) b = 3;
          if (b < 0) b = 0;
          e_en = 1; e_m = 2'b01; e_idx = expc[7:0]; e_bht = b[1:0];
        end
      end else if (q.size() > 0) begin
        ent = q.pop_front();
        e_en = 1; e_m = 2'b11; e_idx = ent[23:16]; e_tag = ent[31:24]; e_tgt = ent[15:0]; e_bht = 2'b10;
      end
      if (idv && exp_ready) q.push_back({idpc, idtgt});
    end
    if (e_en) begin
      if (e_m[1]) mt_tag[e_idx] = int'(e_tag);
      if (e_m[0]) mt_bht[e_idx] = int'(e_bht);
    end
    exp_w = norm(!m_run, e_en, e_m, e_idx, e_tag, e_tgt, e_bht);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    @(negedge clk);
    if ({busy, bus.wr_en, bus.wr_mask, bus.wr_idx, bus.wr_tag, bus.wr_target, bus.wr_bht} !== {1'b1, 37'd0}) begin
      $display("FAIL reset_vals act=%h exp=%h", {busy, bus.wr_en, bus.wr_mask, bus.wr_idx, bus.wr_tag, bus.wr_target, bus.wr_bht}, {1'b1, 37'd0});
      n_bad++;
    end
    n_vec++;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
      if (act_w() !== exp_w) begin
        $display("FAIL clear_walk step=%0d act=%h exp=%h", i, act_w(), exp_w);
        n_bad++;
      end
      n_vec++;
    end
    if ({busy, bus.id_upd_ready} !== 2'b01) begin
      $display("FAIL walk_done busy_ready act=%b exp=01", {busy, bus.id_upd_ready});
      n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_id_push();
    cyc(0, 1, 16'h1234, 16'h0040, 0, 16'h0, 0);
    if (ready_seen !== 1'b1 || act_w() !== exp_w) begin
      $display("FAIL id_push_accept ready=%b act=%h exp=%h", ready_seen, act_w(), exp_w);
      n_bad++;
    end
    n_vec++;
    cyc(0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    if (act_w() !== norm(1'b0, 1'b1, 2'b11, 8'h34, 8'h12, 16'h0040, 2'b10)) begin
      $display("FAIL id_row_write act=%h exp=%h", act_w(), norm(1'b0, 1'b1, 2'b11, 8'h34, 8'h12, 16'h0040, 2'b10));
      n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_bht_counter();
    logic [1:0] want [7];
    logic [15:0] pcs [7];
    logic        tk  [7];
    preset(8'h55, 8'hAB, 2'b11);
    preset(8'h66, 8'hAC, 2'b00);
    preset(8'h77, 8'hAD, 2'b01);
    pcs = '{16'hAB55, 16'hAB55, 16'hAB55, 16'hAB55, 16'hAC66, 16'hAD77, 16'hAD77};
    tk  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    want = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 16'h0, 16'h0, 1, pcs[i], tk[i]);
      if (act_w() !== norm(1'b0, 1'b1, 2'b01, pcs[i][7:0], 8'h0, 16'h0, want[i])) begin
        $display("FAIL bht_update step=%0d act=%h exp_bht=%b", i, act_w(), want[i]);
        n_bad++;
      end
      n_vec++;
    end
    cyc(0, 0, 16'h0, 16'h0, 1, 16'hEE55, 1);
    if (bus.wr_en !== 1'b0) begin
      $display("FAIL tag_miss_nowrite wr_en=%b exp=0", bus.wr_en);
      n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] idpcs [6];
    idpcs = '{16'h0A31, 16'h0B32, 16'h0C33, 16'h0, 16'h0, 16'h0};
    for (int i = 0; i < 6; i++) begin
      cyc(0, i < 3, idpcs[i], 16'h1000 + 16'(i), i < 3, 16'h0110, 1'b1);
      if (i == 2 && ready_seen !== 1'b0) begin
        $display("FAIL fifo_full_ready act=%b exp=0", ready_seen);
        n_bad++;
      end
      if (ready_seen !== exp_ready || act_w() !== exp_w) begin
        $display("FAIL ex_priority step=%0d ready=%b/%b act=%h exp=%h", i, ready_seen, exp_ready, act_w(), exp_w);
        n_bad++;
      end
      n_vec++;
    end
  endtask

  task automatic test_flush();
    cyc(0, 1, 16'h2141, 16'h0777, 1, 16'h0110, 1'b0);
    cyc(0, 1, 16'h2242, 16'h0888, 1, 16'h0110, 1'b0);
    cyc(1, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    if ({busy, bus.wr_en} !== 2'b10) begin
      $display("FAIL flush_enter busy_wr_en act=%b exp=10", {busy, bus.wr_en});
      n_bad++;
    end
    n_vec++;
    for (int i = 0; i < DEPTH + 12; i++) begin
      cyc(i == 10, 1, 16'h2343, 16'h0999, 1, 16'h0110, 1'b1);
      if (ready_seen !== exp_ready || act_w() !== exp_w) begin
        $display("FAIL flush_walk step=%0d ready=%b/%b act=%h exp=%h", i, ready_seen, exp_ready, act_w(), exp_w);
        n_bad++;
      end
      n_vec++;
    end
  endtask

  task automatic test_reset_mid_walk();
    cyc(1, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    idle(100);
    #2 reset_n = 1'b0;
    #1;
    if ({busy, bus.wr_en, bus.wr_mask, bus.wr_idx, bus.wr_tag, bus.wr_target, bus.wr_bht} !== {1'b1, 37'd0}) begin
      $display("FAIL async_reset act=%h exp=%h", {busy, bus.wr_en, bus.wr_mask, bus.wr_idx, bus.wr_tag, bus.wr_target, bus.wr_bht}, {1'b1, 37'd0});
      n_bad++;
    end
    n_vec++;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 16'h0101, 16'h0202, 1, 16'h0101, 1'b1);
      if (ready_seen !== exp_ready || act_w() !== exp_w) begin
        $display("FAIL rewalk step=%0d ready=%b/%b act=%h exp=%h", i, ready_seen, exp_ready, act_w(), exp_w);
        n_bad++;
      end
      n_vec++;
    end
  endtask

  task automatic test_random();
    logic        fl, idv, exv, ext;
    logic [15:0] idpc, idtgt, expc;
    for (int i = 0; i < 1500; i++) begin
      fl    = ($urandom_range(0, 399) == 0);
      idv   = 1'($urandom_range(0, 1));
      idpc  = {8'($urandom_range(1, 2)), 8'(8'h20 + $urandom_range(0, 3))};
      idtgt = 16'($urandom);
      exv   = ($urandom_range(0, 9) < 6);
      expc  = {8'($urandom_range(1, 2)), 8'(8'h20 + $urandom_range(0, 3))};
      ext   = 1'($urandom_range(0, 1));
      cyc(fl, idv, idpc, idtgt, exv, expc, ext);
      if (ready_seen !== exp_ready || act_w() !== exp_w) begin
        $display("FAIL random step=%0d ready=%b/%b act=%h exp=%h", i, ready_seen, exp_ready, act_w(), exp_w);
        n_bad++;
      end
      n_vec++;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      env_tag[i] = '0;
      env_bht[i] = '0;
      mt_tag[i]  = 0;
      mt_bht[i]  = 0;
    end
    flush_req         = 1'b0;
    bus.id_upd_valid  = 1'b0;
    bus.id_upd_pc     = '0;
    bus.id_upd_target = '0;
    bus.ex_upd_valid  = 1'b0;
    bus.ex_upd_pc     = '0;
    bus.ex_upd_taken  = 1'b0;
    model_reset();
    test_reset();
    test_id_push();
    test_bht_counter();
    test_back_to_back();
    test_flush();
    test_reset_mid_walk();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
